// File: rtl/alu_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl_if
// Bundles every non-clock signal of the ALU sequencer into one interface.
//
// Handshake contract (valid/ready):
//   An instruction transfers on a rising clk edge where in_valid and in_ready
//   are both high. The source raises in_valid with a stable instr and keeps
//   both unchanged until that edge. in_ready does not depend on in_valid.
//   in_valid while in_ready is low has no effect.
//
// Signal groups:
//   command : in_valid, in_ready, instr
//   load    : ld_en, ld_addr, ld_data
//   alu bus : alu_op, alu_a, alu_b (to ALU); alu_f, alu_n, alu_c, alu_v (from ALU)
//   status  : done, result, flags
//
// Modports:
//   slave  - the sequencer view
//   master - the command-source / ALU-side view
// -----------------------------------------------------------------------------
interface alu_seq_ctrl_if #(
  parameter int DSIZE  = 16,
  parameter int OPSIZE = 4,
  parameter int AW     = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instr;
  logic              ld_en;
  logic [AW-1:0]     ld_addr;
  logic [DSIZE-1:0]  ld_data;
  logic [OPSIZE-1:0] alu_op;
  logic [DSIZE-1:0]  alu_a;
  logic [DSIZE-1:0]  alu_b;
  logic [DSIZE-1:0]  alu_f;
  logic              alu_n;
  logic              alu_c;
  logic              alu_v;
  logic              done;
  logic [DSIZE-1:0]  result;
  logic [3:0]        flags;

  modport slave (
    input  in_valid, instr, ld_en, ld_addr, ld_data,
    input  alu_f, alu_n, alu_c, alu_v,
    output in_ready, alu_op, alu_a, alu_b, done, result, flags
  );

  modport master (
    output in_valid, instr, ld_en, ld_addr, ld_data,
    output alu_f, alu_n, alu_c, alu_v,
    input  in_ready, alu_op, alu_a, alu_b, done, result, flags
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Multi-cycle instruction sequencer around an external combinational ALU.
// Holds an RF_DEPTH x DSIZE register file and a {Z,N,C,V} flag register.
// Each instruction takes three cycles: IDLE (accept), READ (operand fetch into
// the registered ALU buses), EXEC (capture ALU result, write back, flags).
// done pulses for one cycle after the EXEC edge; that cycle is IDLE again.
//
// instr layout: [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [2] we, [1] fe, [0] cz
//
// Ports:
//   clk         - system clock, all state on rising edge
//   rst         - synchronous active-high reset, aborts any instruction in flight
//   bus         - alu_seq_ctrl_if.slave (command, load, ALU and status signals)
//   dbg_state_o - current FSM state (IDLE=0, READ=1, EXEC=2)
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
  parameter int DSIZE    = 16,
  parameter int OPSIZE   = 4,
  parameter int RF_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_seq_ctrl_if.slave       bus,
  output logic [1:0]          dbg_state_o
);
  localparam int AW = $clog2(RF_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [15:0]       instr_q,   instr_d;
  logic [OPSIZE-1:0] alu_op_q,  alu_op_d;
  logic [DSIZE-1:0]  alu_a_q,   alu_a_d;
  logic [DSIZE-1:0]  alu_b_q,   alu_b_d;
  logic [DSIZE-1:0]  result_q,  result_d;
  logic [3:0]        flags_q,   flags_d;
  logic              done_q,    done_d;
  logic [DSIZE-1:0]  rf_q [RF_DEPTH];
  logic [DSIZE-1:0]  rf_d [RF_DEPTH];

  // Fields of the captured instruction.
  logic [OPSIZE-1:0] op_w;
  logic [AW-1:0]     rd_w;
  logic [AW-1:0]     ra_w;
  logic [AW-1:0]     rb_w;
  logic              we_w;
  logic              fe_w;
  logic              cz_w;
  logic              commit_w;

  assign op_w = instr_q[15 -: OPSIZE];
  assign rd_w = instr_q[9 +: AW];
  assign ra_w = instr_q[6 +: AW];
  assign rb_w = instr_q[3 +: AW];
  assign we_w = instr_q[2];
  assign fe_w = instr_q[1];
  assign cz_w = instr_q[0];

  // Conditional write-back looks at Z as it stood before this instruction,
  // so flags_q (not flags_d) is used here.
  assign commit_w = we_w & (~cz_w | flags_q[3]);

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    rf_d     = rf_q;

    case (state_q)
      IDLE: begin
        // Loads are only honoured here, so they can never collide with a
        // write-back. A load and an accept on the same edge both take effect;
        // the following READ sees the loaded value.
        if (bus.ld_en) begin
          rf_d[bus.ld_addr] = bus.ld_data;
        end
        if (bus.in_valid) begin
          instr_d = bus.instr;
          state_d = READ;
        end
      end
      READ: begin
        alu_op_d = op_w;
        alu_a_d  = rf_q[ra_w];
        alu_b_d  = rf_q[rb_w];
        state_d  = EXEC;
      end
      EXEC: begin
        result_d = bus.alu_f;
        done_d   = 1'b1;
        if (commit_w) begin
          rf_d[rd_w] = bus.alu_f;
        end
        if (fe_w) begin
          flags_d = {(bus.alu_f == '0), bus.alu_n, bus.alu_c, bus.alu_v};
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      rf_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      rf_q     <= rf_d;
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.alu_op   = alu_op_q;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.result   = result_q;
  assign bus.flags    = flags_q;
  assign bus.done     = done_q;
  assign dbg_state_o  = state_q;
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle instruction sequencer wrapped around the team's 16-bit, 4-bit-opcode combinational ALU, which is instantiated externally.
- Owns an 8-entry x DSIZE register file and a Z/N/C/V flag register.
- Accepts one packed instruction at a time over a valid/ready handshake, reads operands, and drives registered op/operand buses to the ALU.
- Captures the ALU result, writes it back conditionally, and reports completion.
- Sits between the command source (test harness / future decoder) and the ALU datapath.

Parameters:
DSIZE, 16, datapath width; must match the ALU DSIZE.
OPSIZE, 4, ALU opcode width; must match the ALU OPSIZE.
RF_DEPTH, 8, register-file entries (address width log2 = 3).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  instruction valid
in_ready  output  1  controller can accept an instruction (high only in IDLE)
instr  input  16  [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [2] we, [1] fe, [0] cz
ld_en  input  1  register-file load strobe
ld_addr  input  3  load address
ld_data  input  DSIZE  load data
alu_op  output  OPSIZE  registered opcode to ALU
alu_a  output  DSIZE  registered operand A to ALU
alu_b  output  DSIZE  registered operand B to ALU
alu_f  input  DSIZE  ALU result
alu_n, alu_c, alu_v  input  1 each  ALU flags
done  output  1  one-cycle pulse: instruction retired
result  output  DSIZE  last ALU result, held until next retire
flags  output  4  {Z,N,C,V} flag register

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset rst.
- Reset values:
  - state = IDLE.
  - alu_op, alu_a, alu_b, result = 0.
  - flags = 4'b0000, done = 0.
  - All register-file entries = 0.
  - Captured instruction = 0.
  - Reset in any state aborts the instruction in flight: no write-back, no done pulse.
- States: IDLE, READ, EXEC.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture instr and go to READ. This is the accept edge E0.
- READ:
  - in_ready = 0.
  - At the edge (E1): alu_op <= op, alu_a <= rf[ra], alu_b <= rf[rb]; go to EXEC.
- EXEC:
  - in_ready = 0. The ALU output is valid this cycle.
  - At the edge (E2): result <= alu_f; done <= 1 (registered, so high for exactly the next cycle); go to IDLE.
  - Write-back commit = we & (~cz | flags.Z). Z is the value of the flag register before this instruction's update.
  - If commit, rf[rd] <= alu_f.
  - If fe, flags <= {(alu_f == 0), alu_n, alu_c, alu_v}. The flag update is independent of cz.
- Latency and throughput:
  - done is asserted in the cycle after E2, i.e. 3 clocks after acceptance.
  - That same cycle is IDLE, so the next instruction can be accepted there.
  - Peak throughput is 1 instruction per 3 clocks.
- Hazards: none. A write at E2 is visible to any later instruction's READ.
- Load port:
  - ld_en is honoured only in IDLE; ignored (dropped) in READ or EXEC.
  - If ld_en and in_valid coincide in IDLE, both take effect. The instruction's READ then sees the loaded value.
  - A load and a write-back can never coincide, because write-back happens only at the EXEC edge.
- Opcode handling:
  - The controller passes op through unmodified; no decoding beyond field extraction.
  - For logic ops (op[3] = 1) the ALU returns n/c/v = 0, and these are stored as-is.
- Outputs hold their last value between instructions (alu_*, result, flags).
- in_valid while not ready: ignored. The source must hold instr until it sees in_ready & in_valid.

Test Plan:
1. Reset then idle:
   - Stimulus: assert rst 2 cycles; release.
   - Required: in_ready = 1, done = 0, flags = 0000, result = 0000; loads of r0..r7 = 0 read back via op 4'b0000 (pass A).
2. Signed overflow:
   - Stimulus: load r1 = 0x7FFF, r2 = 0x0001; instr op = 0100, rd = 3, ra = 1, rb = 2, we = fe = 1.
   - Required: done exactly 3 clocks after accept; result = 0x8000; flags Z/N/C/V = 0/1/0/1; r3 = 0x8000.
3. Subtract-to-zero carry:
   - Stimulus: op = 0011, ra = rb = 2 (0x0001), rd = 4, we = fe = 1.
   - Required: result = 0x0000, flags = 1010, r4 = 0.
4. Conditional write:
   - Stimulus: after test 3 (Z = 1), op = 1010 (XOR) r1^r2, rd = 5, we = 1, cz = 1, fe = 1.
   - Required: r5 = 0x7FFE, flags = 0000.
   - Stimulus: repeat with rd = 6, cz = 1.
   - Required: r6 unchanged (0), flags = 0000.
5. Back-to-back and dropped load:
   - Stimulus: hold in_valid high with two instructions; pulse ld_en (r7 = 0x1234) during READ.
   - Required: accepts spaced 3 clocks apart; r7 stays 0.
   - Stimulus: repeat the ld_en pulse in IDLE.
   - Required: r7 = 0x1234.
6. Reset mid-operation:
   - Stimulus: assert rst during EXEC of op = 0100 writing r3.
   - Required: no done pulse; r3 = 0; state IDLE with in_ready = 1 the cycle after rst deasserts.
